wb_writer: RTL and testbench

Writeback-stage sequencer that owns the processor register file's write side. It accepts one retiring instruction per handshake from the MEM/WB pipeline register and drives the single general-register write port, the SP write port and the CCR input. Instructions with two destination registers, such as SWAP, are serialized over two cycles, and upstream is stalled for the extra cycle. It also exports forwarding information and a retired-instruction count.

---
 rtl/wb_writer.sv | 107 ++++++++++
 tb/tb_wb_writer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_writer.sv
// Writeback-stage sequencer: drives the register file write side from the
// MEM/WB register. Dual-destination instructions take two write beats.
module wb_writer #(
   parameter int REG_SIZE = 16,
   parameter int CCR_SIZE = 16,
   parameter int ADDR_W   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_wr1,
   input  logic                in_wr2,
   input  logic [ADDR_W-1:0]   in_addr1,
   input  logic [ADDR_W-1:0]   in_addr2,
   input  logic [REG_SIZE-1:0] in_data1,
   input  logic [REG_SIZE-1:0] in_data2,
   input  logic                in_sp_wr,
   input  logic [31:0]         in_sp_data,
   input  logic                in_ccr_wr,
   input  logic [CCR_SIZE-1:0] in_ccr_data,
   output logic                Data_write1,
   output logic [ADDR_W-1:0]   write_addr1,
   output logic [REG_SIZE-1:0] write_data1,
   output logic                sp_write,
   output logic [31:0]         write_sp_data,
   output logic [CCR_SIZE-1:0] write_ccr,
   output logic                fwd_valid,
   output logic [ADDR_W-1:0]   fwd_addr,
   output logic [REG_SIZE-1:0] fwd_data,
   output logic [31:0]         retired
);

   typedef enum logic {IDLE, SECOND} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   addr2_q;
   logic [REG_SIZE-1:0] data2_q;
   logic                accept;

   // Upstream may only hand over an instruction when no second beat is pending.
   assign in_ready = rst & (state == IDLE);
   assign accept   = in_valid & in_ready;

   // Forwarding sees exactly what the register file is being written with.
   assign fwd_valid = Data_write1;
   assign fwd_addr  = write_addr1;
   assign fwd_data  = write_data1;

   // Beat sequencer: first beat carries slot 1 (or the only slot) plus SP/CCR,
   // the optional second beat carries the held slot 2.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         addr2_q       <= '0;
         data2_q       <= '0;
         Data_write1   <= 1'b0;
         write_addr1   <= '0;
         write_data1   <= '0;
         sp_write      <= 1'b0;
         write_sp_data <= '0;
         write_ccr     <= '0;
         retired       <= '0;
      end else begin
         Data_write1 <= 1'b0;
         sp_write    <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  sp_write <= in_sp_wr;
                  if (in_sp_wr)
                     write_sp_data <= in_sp_data;
                  // CCR is loaded every cycle downstream, so hold the last flags.
                  if (in_ccr_wr)
                     write_ccr <= in_ccr_data;
                  if (in_wr1) begin
                     Data_write1 <= 1'b1;
                     write_addr1 <= in_addr1;
                     write_data1 <= in_data1;
                  end else if (in_wr2) begin
                     Data_write1 <= 1'b1;
                     write_addr1 <= in_addr2;
                     write_data1 <= in_data2;
                  end
                  if (in_wr1 && in_wr2) begin
                     addr2_q <= in_addr2;
                     data2_q <= in_data2;
                     state   <= SECOND;
                  end else begin
                     retired <= retired + 32'd1;
                  end
               end
            end
            SECOND: begin
               // Slot 2 always lands last, so it wins on equal addresses.
               Data_write1 <= 1'b1;
               write_addr1 <= addr2_q;
               write_data1 <= data2_q;
               retired     <= retired + 32'd1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_writer.sv
// Directed bench for wb_writer: reset, single/dual writes, SP/CCR, stalls.
module tb_wb_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_wr1, in_wr2;
   logic [3:0]  in_addr1, in_addr2;
   logic [15:0] in_data1, in_data2;
   logic        in_sp_wr;
   logic [31:0] in_sp_data;
   logic        in_ccr_wr;
   logic [15:0] in_ccr_data;
   logic        Data_write1, sp_write, fwd_valid;
   logic [3:0]  write_addr1, fwd_addr;
   logic [15:0] write_data1, write_ccr, fwd_data;
   logic [31:0] write_sp_data, retired;

   int n_chk  = 0;
   int n_fail = 0;

   logic [20:0] wb_obs, wb_exp;

   wb_writer #(.REG_SIZE(16), .CCR_SIZE(16), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_wr1(in_wr1), .in_wr2(in_wr2),
      .in_addr1(in_addr1), .in_addr2(in_addr2),
      .in_data1(in_data1), .in_data2(in_data2),
      .in_sp_wr(in_sp_wr), .in_sp_data(in_sp_data),
      .in_ccr_wr(in_ccr_wr), .in_ccr_data(in_ccr_data),
      .Data_write1(Data_write1), .write_addr1(write_addr1), .write_data1(write_data1),
      .sp_write(sp_write), .write_sp_data(write_sp_data), .write_ccr(write_ccr),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .retired(retired)
   );

   always #5 clk = ~clk;

   // Present one instruction on the MEM/WB side.
   task automatic send(input logic w1, input logic w2,
                       input logic [3:0] a1, input logic [3:0] a2,
                       input logic [15:0] d1, input logic [15:0] d2,
                       input logic spw, input logic [31:0] spd,
                       input logic cw, input logic [15:0] cd);
      in_valid = 1'b1; in_wr1 = w1; in_wr2 = w2;
      in_addr1 = a1; in_addr2 = a2; in_data1 = d1; in_data2 = d2;
      in_sp_wr = spw; in_sp_data = spd; in_ccr_wr = cw; in_ccr_data = cd;
   endtask

   task automatic idle_in();
      in_valid = 1'b0; in_wr1 = 1'b0; in_wr2 = 1'b0;
      in_addr1 = '0; in_addr2 = '0; in_data1 = '0; in_data2 = '0;
      in_sp_wr = 1'b0; in_sp_data = '0; in_ccr_wr = 1'b0; in_ccr_data = '0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      send(1'b1, 1'b0, 4'd6, 4'd0, 16'h1234, 16'h0, 1'b1, 32'h55, 1'b1, 16'h9);
      step(); step();
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_low: got %b want 0", in_ready); end
      n_chk++; if ({Data_write1, write_addr1, write_data1, sp_write, write_sp_data, write_ccr,
                    fwd_valid, fwd_addr, fwd_data, retired} !== 123'd0) begin
         n_fail++; $display("FAIL rst_outputs: some output nonzero dw=%b sp=%b ccr=%h ret=%0d", Data_write1, sp_write, write_ccr, retired);
      end
      idle_in();
      rst = 1'b1;
      step();
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
      n_chk++; if ({Data_write1, sp_write, write_ccr, retired} !== 50'd0) begin
         n_fail++; $display("FAIL rst_release_out: dw=%b sp=%b ccr=%h ret=%0d want all 0", Data_write1, sp_write, write_ccr, retired);
      end
   endtask

   task automatic test_single();
      send(1'b1, 1'b0, 4'd3, 4'd0, 16'hBEEF, 16'h0, 1'b0, 32'h0, 1'b0, 16'h0);
      step(); idle_in();
      wb_obs = {Data_write1, write_addr1, write_data1}; wb_exp = {1'b1, 4'd3, 16'hBEEF};
      n_chk++; if (wb_obs !== wb_exp) begin n_fail++; $display("FAIL single_wr: got %h want %h", wb_obs, wb_exp); end
      wb_obs = {fwd_valid, fwd_addr, fwd_data};
      n_chk++; if (wb_obs !== wb_exp) begin n_fail++; $display("FAIL single_fwd: got %h want %h", wb_obs, wb_exp); end
      n_chk++; if (retired !== 32'd1) begin n_fail++; $display("FAIL single_retired: got %0d want 1", retired); end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", in_ready); end
      step();
      n_chk++; if ({Data_write1, sp_write} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got dw=%b sp=%b want 0 0", Data_write1, sp_write); end
   endtask

   task automatic test_swap();
      send(1'b1, 1'b1, 4'd2, 4'd5, 16'h1111, 16'h2222, 1'b0, 32'h0, 1'b0, 16'h0);
      step(); idle_in();
      wb_obs = {Data_write1, write_addr1, write_data1}; wb_exp = {1'b1, 4'd2, 16'h1111};
      n_chk++; if (wb_obs !== wb_exp) begin n_fail++; $display("FAIL swap_beat1: got %h want %h", wb_obs, wb_exp); end
      n_chk++; if ({in_ready, retired} !== {1'b0, 32'd1}) begin n_fail++; $display("FAIL swap_beat1_ctl: ready=%b ret=%0d want 0 1", in_ready, retired); end
      step();
      wb_obs = {Data_write1, write_addr1, write_data1}; wb_exp = {1'b1, 4'd5, 16'h2222};
      n_chk++; if (wb_obs !== wb_exp) begin n_fail++; $display("FAIL swap_beat2: got %h want %h", wb_obs, wb_exp); end
      n_chk++; if ({in_ready, retired} !== {1'b1, 32'd2}) begin n_fail++; $display("FAIL swap_beat2_ctl: ready=%b ret=%0d want 1 2", in_ready, retired); end
      step();
      n_chk++; if ({Data_write1, retired} !== {1'b0, 32'd2}) begin n_fail++; $display("FAIL swap_after: dw=%b ret=%0d want 0 2", Data_write1, retired); end
   endtask

   // SWAP immediately followed by a single write held through the stall cycle.
   task automatic test_back_to_back();
      send(1'b1, 1'b1, 4'd8, 4'd9, 16'hA0A0, 16'hB0B0, 1'b0, 32'h0, 1'b0, 16'h0);
      step();
      send(1'b1, 1'b0, 4'd7, 4'd0, 16'h7777, 16'h0, 1'b0, 32'h0, 1'b0, 16'h0);
      wb_obs = {Data_write1, write_addr1, write_data1}; wb_exp = {1'b1, 4'd8, 16'hA0A0};
      n_chk++; if (wb_obs !== wb_exp) begin n_fail++; $display("FAIL b2b_beat1: got %h want %h", wb_obs, wb_exp); end
      step();
      wb_obs = {Data_write1, write_addr1, write_data1}; wb_exp = {1'b1, 4'd9, 16'hB0B0};
      n_chk++; if (wb_obs !== wb_exp) begin n_fail++; $display("FAIL b2b_beat2: got %h want %h", wb_obs, wb_exp); end
      step(); idle_in();
      wb_obs = {Data_write1, write_addr1, write_data1}; wb_exp = {1'b1, 4'd7, 16'h7777};
      n_chk++; if (wb_obs !== wb_exp) begin n_fail++; $display("FAIL b2b_next: got %h want %h", wb_obs, wb_exp); end
      n_chk++; if (retired !== 32'd4) begin n_fail++; $display("FAIL b2b_retired: got %0d want 4", retired); end
      step();
      n_chk++; if (Data_write1 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got dw=%b want 0", Data_write1); end
   endtask

   task automatic test_wr2_only();
      send(1'b0, 1'b1, 4'd1, 4'd12, 16'hDEAD, 16'h9999, 1'b0, 32'h0, 1'b0, 16'h0);
      step(); idle_in();
      wb_obs = {Data_write1, write_addr1, write_data1}; wb_exp = {1'b1, 4'd12, 16'h9999};
      n_chk++; if (wb_obs !== wb_exp) begin n_fail++; $display("FAIL wr2_only: got %h want %h", wb_obs, wb_exp); end
      n_chk++; if ({in_ready, retired} !== {1'b1, 32'd5}) begin n_fail++; $display("FAIL wr2_only_ctl: ready=%b ret=%0d want 1 5", in_ready, retired); end
      step();
   endtask

   task automatic test_sp_ccr();
      send(1'b0, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b1, 32'h7FE, 1'b1, 16'h0004);
      step();
      send(1'b0, 1'b0, 4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 32'h123, 1'b0, 16'hFFFF);
      n_chk++; if ({sp_write, write_sp_data} !== {1'b1, 32'h7FE}) begin n_fail++; $display("FAIL sp_pulse: got %b/%h want 1/7fe", sp_write, write_sp_data); end
      n_chk++; if ({Data_write1, write_ccr, retired} !== {1'b0, 16'h0004, 32'd6}) begin
         n_fail++; $display("FAIL ccr_first: dw=%b ccr=%h ret=%0d want 0 0004 6", Data_write1, write_ccr, retired);
      end
      step(); idle_in();
      n_chk++; if ({sp_write, write_sp_data} !== {1'b0, 32'h7FE}) begin n_fail++; $display("FAIL sp_after: got %b/%h want 0/7fe", sp_write, write_sp_data); end
      n_chk++; if ({Data_write1, write_ccr, retired} !== {1'b0, 16'h0004, 32'd7}) begin
         n_fail++; $display("FAIL ccr_hold: dw=%b ccr=%h ret=%0d want 0 0004 7", Data_write1, write_ccr, retired);
      end
      step();
   endtask

   task automatic test_same_addr();
      send(1'b1, 1'b1, 4'd1, 4'd1, 16'hAAAA, 16'h5555, 1'b0, 32'h0, 1'b0, 16'h0);
      step(); idle_in();
      wb_obs = {Data_write1, write_addr1, write_data1}; wb_exp = {1'b1, 4'd1, 16'hAAAA};
      n_chk++; if (wb_obs !== wb_exp) begin n_fail++; $display("FAIL same_beat1: got %h want %h", wb_obs, wb_exp); end
      step();
      wb_obs = {Data_write1, write_addr1, write_data1}; wb_exp = {1'b1, 4'd1, 16'h5555};
      n_chk++; if (wb_obs !== wb_exp) begin n_fail++; $display("FAIL same_beat2: got %h want %h", wb_obs, wb_exp); end
      n_chk++; if ({write_ccr, retired} !== {16'h0004, 32'd8}) begin n_fail++; $display("FAIL same_ctl: ccr=%h ret=%0d want 0004 8", write_ccr, retired); end
      step();
   endtask

   task automatic test_reset_second();
      send(1'b1, 1'b1, 4'd4, 4'd6, 16'h4444, 16'h6666, 1'b0, 32'h0, 1'b0, 16'h0);
      step(); idle_in();
      wb_obs = {Data_write1, write_addr1, write_data1}; wb_exp = {1'b1, 4'd4, 16'h4444};
      n_chk++; if (wb_obs !== wb_exp) begin n_fail++; $display("FAIL rs_beat1: got %h want %h", wb_obs, wb_exp); end
      rst = 1'b0;
      step();
      n_chk++; if ({Data_write1, retired, in_ready} !== {1'b0, 32'd0, 1'b0}) begin
         n_fail++; $display("FAIL rs_dropped: dw=%b ret=%0d ready=%b want 0 0 0", Data_write1, retired, in_ready);
      end
      rst = 1'b1;
      step();
      n_chk++; if ({Data_write1, retired, in_ready} !== {1'b0, 32'd0, 1'b1}) begin
         n_fail++; $display("FAIL rs_after: dw=%b ret=%0d ready=%b want 0 0 1", Data_write1, retired, in_ready);
      end
   endtask

   initial begin
      idle_in();
      rst = 1'b0;
      test_reset();
      test_single();
      test_swap();
      test_back_to_back();
      test_wr2_only();
      test_sp_ccr();
      test_same_addr();
      test_reset_second();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
